// File: rtl/hamming_enc_arbiter_pkg.sv
// Shared constants for the round-robin (7,4) Hamming encoder arbiter.
// State encodings are plain constants so older netlists keep their binary codes.
package hamming_enc_arbiter_pkg;

    localparam int CW_W   = 7;
    localparam int NIB_W  = 4;
    localparam int BYTE_W = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOW  = 2'd1;
    localparam logic [1:0] HIGH = 2'd2;

endpackage

// File: rtl/hamming_enc_arbiter_encoder.sv
// Combinational (7,4) Hamming encoder: data bits at 2,4,5,6, parity at 0,1,3.
module hamming_enc_arbiter_encoder
    import hamming_enc_arbiter_pkg::*;
(
    input  logic [NIB_W-1:0] nibble,
    output logic [CW_W-1:0]  codeword
);

    assign codeword[0] = nibble[0] ^ nibble[1] ^ nibble[3];
    assign codeword[1] = nibble[0] ^ nibble[2] ^ nibble[3];
    assign codeword[2] = nibble[0];
    assign codeword[3] = nibble[1] ^ nibble[2] ^ nibble[3];
    assign codeword[4] = nibble[1];
    assign codeword[5] = nibble[2];
    assign codeword[6] = nibble[3];

endmodule

// File: rtl/hamming_enc_arbiter.sv
// Round-robin arbiter feeding one shared Hamming encoder; each granted byte
// leaves as two tagged codewords, low nibble first.
module hamming_enc_arbiter
    import hamming_enc_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*8-1:0]     req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     cw_valid,
    output logic [CW_W-1:0]          cw_data,
    output logic [IDW-1:0]           cw_id,
    output logic                     cw_last,
    input  logic                     cw_ready,
    output logic                     busy
);

    logic [1:0]        state_reg, state_next;
    logic [BYTE_W-1:0] byte_reg;
    logic [IDW-1:0]    id_reg;
    logic [IDW-1:0]    rr_ptr_reg;
    logic [IDW-1:0]    grant_idx;
    logic [IDW-1:0]    search_idx;
    logic              any_valid;
    logic              accept;
    logic [NIB_W-1:0]  enc_nibble;
    logic [CW_W-1:0]   enc_codeword;
    logic [BYTE_W-1:0] req_bytes [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_bytes[gi] = req_data[BYTE_W*gi +: BYTE_W];
            assign req_ready[gi] = accept && (grant_idx == IDW'(gi));
        end
    endgenerate

    // Walk from the farthest candidate to the nearest so the one just after
    // rr_ptr overwrites everything else and wins.
    always_comb begin
        grant_idx  = '0;
        any_valid  = 1'b0;
        search_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            search_idx = IDW'((int'(rr_ptr_reg) + k) % NUM_REQ);
            if (req_valid[search_idx]) begin
                grant_idx = search_idx;
                any_valid = 1'b1;
            end
        end
    end

    // rst_n gate keeps req_ready quiet while the block is held in reset.
    assign accept = rst_n && any_valid &&
                    ((state_reg == IDLE) || ((state_reg == HIGH) && cw_ready));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = LOW;
            LOW:     if (cw_ready) state_next = HIGH;
            HIGH:    if (cw_ready) state_next = accept ? LOW : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            byte_reg   <= '0;
            id_reg     <= '0;
            rr_ptr_reg <= IDW'(NUM_REQ - 1);
        end else begin
            state_reg <= state_next;
            if (accept) begin
                byte_reg   <= req_bytes[grant_idx];
                id_reg     <= grant_idx;
                rr_ptr_reg <= grant_idx;
            end
        end
    end

    assign enc_nibble = (state_reg == HIGH) ? byte_reg[7:4] : byte_reg[3:0];

    hamming_enc_arbiter_encoder u_encoder (
        .nibble   (enc_nibble),
        .codeword (enc_codeword)
    );

    assign cw_valid = (state_reg != IDLE);
    assign busy     = (state_reg != IDLE);
    assign cw_data  = cw_valid ? enc_codeword : '0;
    assign cw_id    = cw_valid ? id_reg : '0;
    assign cw_last  = (state_reg == HIGH);

endmodule
